// File: rtl/ssd_pkg.sv
// ---------------------------------------------------------------------------
// ssd_pkg
// Shared definitions for the seven-segment scan controller:
//   SEG_OFF   - active-low cathode pattern with every segment and DP dark
//   HEX_FONT  - 16-entry active-low {a,b,c,d,e,f,g} font for hex nibbles
//   idx_width - width of a digit index able to address n digits
// ---------------------------------------------------------------------------
package ssd_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low segments, bit order {a,b,c,d,e,f,g}.
    localparam logic [6:0] HEX_FONT [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// ---------------------------------------------------------------------------
// ssd_hex_decode
// Combinational hex-nibble to active-low cathode decoder.
//   nibble   in  4  hex value to display
//   dp       in  1  1 = light the decimal point
//   cathodes out 8  active-low {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}
// ---------------------------------------------------------------------------
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] cathodes
);

    always_comb begin
        cathodes = {HEX_FONT[nibble], ~dp};
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ssd_scan_ctrl
// Time-multiplexed scan controller for a NUM_DIGITS seven-segment display.
// Each digit owns a slot of 2**SCAN_DIV_W clocks; the first GUARD_CYCLES of a
// slot keep all anodes off to avoid ghosting. Display data is double
// buffered: load fills a pending register, which is copied into the shadow
// register only when the digit index wraps to 0, so a frame is never torn.
//
// Ports
//   ClkPort     in  1             system clock, rising edge
//   Reset       in  1             synchronous, active-high
//   digits_in   in  4*NUM_DIGITS  hex nibble per digit, digit i at [4i+3:4i]
//   dp_in       in  NUM_DIGITS    1 = decimal point of digit i lit
//   blank_in    in  NUM_DIGITS    1 = digit i dark
//   load        in  1             strobe capturing digits_in/dp_in/blank_in
//   brightness  in  4             PWM duty code (SSD_BRIGHTNESS_EN builds only)
//   An          out NUM_DIGITS    active-low one-hot anodes (registered)
//   Cathodes    out 8             active-low {Ca..Cg,Dp} (registered)
//   frame_start out 1             one-cycle pulse with first digit-0 output
//
// Build option
//   SSD_BRIGHTNESS_EN  when defined, a 16-level PWM gate driven by the top
//                      four phase bits limits the lit time of each slot;
//                      brightness is sampled at each frame wrap.
// ---------------------------------------------------------------------------
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV_W   = 18,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                      ClkPort,
    input  logic                      Reset,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    input  logic                      load,
    input  logic [3:0]                brightness,
    output logic [NUM_DIGITS-1:0]     An,
    output logic [7:0]                Cathodes,
    output logic                      frame_start
);

    localparam int unsigned IDX_W = idx_width(NUM_DIGITS);
    localparam int LAST_INT = NUM_DIGITS - 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(LAST_INT);
    localparam logic [SCAN_DIV_W-1:0] GUARD    = SCAN_DIV_W'(GUARD_CYCLES);

    logic [SCAN_DIV_W-1:0]   phase;
    logic [IDX_W-1:0]        idx;
    logic                    phase_term;
    logic                    wrap;
    logic                    wrap_q;

    logic [4*NUM_DIGITS-1:0] pend_digits, shad_digits;
    logic [NUM_DIGITS-1:0]   pend_dp,     shad_dp;
    logic [NUM_DIGITS-1:0]   pend_blank,  shad_blank;

    logic                    gate_open;
    logic                    lit;
    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic [7:0]              dec_cath;
    logic [NUM_DIGITS-1:0]   an_nxt;

    assign phase_term = &phase;
    assign wrap       = phase_term && (idx == LAST_IDX);

    // Prescaler and digit index.
    always_ff @(posedge ClkPort) begin
        if (Reset) begin
            phase <= '0;
            idx   <= '0;
        end else begin
            phase <= phase + 1'b1;
            if (phase_term) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

    // Double buffer. A load on the wrap cycle bypasses pending so the new
    // data is shown in the frame that is just starting.
    always_ff @(posedge ClkPort) begin
        if (Reset) begin
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_blank  <= '1;
            shad_digits <= '0;
            shad_dp     <= '0;
            shad_blank  <= '1;
        end else begin
            if (load) begin
                pend_digits <= digits_in;
                pend_dp     <= dp_in;
                pend_blank  <= blank_in;
            end
            if (wrap) begin
                shad_digits <= load ? digits_in : pend_digits;
                shad_dp     <= load ? dp_in     : pend_dp;
                shad_blank  <= load ? blank_in  : pend_blank;
            end
        end
    end

`ifdef SSD_BRIGHTNESS_EN
    logic [3:0] bright_q;

    always_ff @(posedge ClkPort) begin
        if (Reset) begin
            bright_q <= 4'hF;
        end else if (wrap) begin
            bright_q <= brightness;
        end
    end

    // Top four phase bits split each slot into 16 PWM steps.
    assign gate_open = (phase[SCAN_DIV_W-1 -: 4] <= bright_q);
`else
    logic unused_brightness;

    assign unused_brightness = ^brightness;
    assign gate_open         = 1'b1;
`endif

    assign lit        = (phase >= GUARD) && !shad_blank[idx] && gate_open;
    assign cur_nibble = shad_digits[{idx, 2'b00} +: 4];
    assign cur_dp     = shad_dp[idx];

    ssd_hex_decode u_hex_decode (
        .nibble   (cur_nibble),
        .dp       (cur_dp),
        .cathodes (dec_cath)
    );

    // At most one anode is ever selected because only idx can match.
    always_comb begin
        an_nxt = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (lit && (idx == IDX_W'(i))) begin
                an_nxt[i] = 1'b0;
            end
        end
    end

    // Registered outputs; frame_start goes through two stages so it lines
    // up with the first registered output of digit 0 after the wrap.
    always_ff @(posedge ClkPort) begin
        if (Reset) begin
            An          <= '1;
            Cathodes    <= SEG_OFF;
            wrap_q      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            An          <= an_nxt;
            Cathodes    <= lit ? dec_cath : SEG_OFF;
            wrap_q      <= wrap;
            frame_start <= wrap_q;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_ctrl
// Directed bench for ssd_scan_ctrl with NUM_DIGITS=4, SCAN_DIV_W=5,
// GUARD_CYCLES=2 (32-cycle slots, 128-cycle frames). The variable t counts
// rising edges since reset release; outputs seen in interval t reflect the
// scan state of interval t-1. Brightness steps run when SSD_BRIGHTNESS_EN
// is defined.
// ---------------------------------------------------------------------------
module tb_ssd_scan_ctrl;

    logic        ClkPort = 1'b0;
    logic        Reset;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic [3:0]  brightness;
    logic [3:0]  An;
    logic [7:0]  Cathodes;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    int t      = 0;

    always #5 ClkPort = ~ClkPort;

    ssd_scan_ctrl #(
        .NUM_DIGITS   (4),
        .SCAN_DIV_W   (5),
        .GUARD_CYCLES (2)
    ) dut (
        .ClkPort     (ClkPort),
        .Reset       (Reset),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .load        (load),
        .brightness  (brightness),
        .An          (An),
        .Cathodes    (Cathodes),
        .frame_start (frame_start)
    );

    task automatic tick();
        @(posedge ClkPort);
        t = t + 1;
        #2;
    endtask

    task automatic go_to(input int n);
        while (t < n) tick();
    endtask

    task automatic chk_out(input string tag, input logic [3:0] an_exp,
                           input logic [7:0] cath_exp);
        checks++;
        assert (An === an_exp) else begin
            errors++;
            $error("FAIL %s t=%0d An got %b want %b", tag, t, An, an_exp);
        end
        checks++;
        assert (Cathodes === cath_exp) else begin
            errors++;
            $error("FAIL %s t=%0d Cathodes got %h want %h", tag, t, Cathodes, cath_exp);
        end
    endtask

    task automatic chk_fs(input string tag, input logic fs_exp);
        checks++;
        assert (frame_start === fs_exp) else begin
            errors++;
            $error("FAIL %s t=%0d frame_start got %b want %b", tag, t, frame_start, fs_exp);
        end
    endtask

    // Dark display expected every cycle; frame_start on t = 129, 257, ...
    task automatic idle_check(input int n_end);
        while (t < n_end) begin
            tick();
            chk_out("idle", 4'hF, 8'hFF);
            chk_fs("idle_fs", (t > 128) && (t % 128 == 1));
        end
    endtask

    // Checks the 128 output cycles of the frame whose scan states start at
    // base. cath holds the lit pattern of digit d at [8d+7:8d].
    task automatic check_frame(input string tag, input int base,
                               input logic [31:0] cath, input logic [3:0] blank,
                               input int pmax);
        for (int i = 0; i < 128; i++) begin
            int   d;
            int   p;
            logic on;
            go_to(base + 1 + i);
            d  = i / 32;
            p  = i % 32;
            on = (p >= 2) && (p <= pmax) && !blank[d];
            chk_out(tag, on ? ~(4'b0001 << d) : 4'hF, on ? cath[8*d +: 8] : 8'hFF);
            chk_fs(tag, i == 0);
        end
    endtask

    task automatic do_load(input logic [15:0] dg, input logic [3:0] dp,
                           input logic [3:0] bl);
        digits_in = dg;
        dp_in     = dp;
        blank_in  = bl;
        load      = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0d simulation did not complete", t);
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset      = 1'b1;
        load       = 1'b0;
        digits_in  = '0;
        dp_in      = '0;
        blank_in   = '0;
        brightness = 4'd15;
        repeat (3) @(posedge ClkPort);
        #2;
        Reset = 1'b0;
        t     = 0;

        chk_out("reset", 4'hF, 8'hFF);
        chk_fs("reset_fs", 1'b0);

        // No load: dark, frame_start at 129 and 257.
        idle_check(260);

        // 1C80 with DP on digit 1, shown in the frame starting at state 384.
        do_load(16'h1C80, 4'b0010, 4'b0000);
        check_frame("frame_1c80", 384, {8'h9F, 8'h63, 8'h00, 8'h03}, 4'b0000, 31);

        // Two loads in one frame: current frame keeps 1C80, next shows 5678.
        go_to(520);
        do_load(16'h1234, 4'b0000, 4'b0000);
        go_to(560);
        do_load(16'h5678, 4'b0000, 4'b0000);
        go_to(580);
        chk_out("old_d2", 4'b1011, 8'h63);
        go_to(610);
        chk_out("old_d3_guard", 4'hF, 8'hFF);
        go_to(612);
        chk_out("old_d3", 4'b0111, 8'h9F);
        check_frame("frame_5678", 640, {8'h49, 8'h41, 8'h1F, 8'h01}, 4'b0000, 31);

        // Load on the wrap cycle (state 895) shows in the frame just starting.
        go_to(895);
        do_load(16'hFFFF, 4'b0000, 4'b0000);
        check_frame("frame_wrap_load", 896, {4{8'h71}}, 4'b0000, 31);

        // Blanked digit 0, DPs on digits 0 and 3.
        go_to(1030);
        do_load(16'hFFFF, 4'b1001, 4'b0001);
        check_frame("frame_blank_dp", 1152, {8'h70, 8'h71, 8'h71, 8'hFF}, 4'b0001, 31);

        // Pending load then reset in the middle of digit 2's slot.
        go_to(1290);
        do_load(16'h2222, 4'b0000, 4'b0000);
        go_to(1354);
        chk_out("pre_reset_d2", 4'b1011, 8'h71);
        Reset = 1'b1;
        tick();
        chk_out("mid_reset", 4'hF, 8'hFF);
        chk_fs("mid_reset_fs", 1'b0);
        Reset = 1'b0;
        t     = 0;

        // Pending data was discarded and the scan restarted at digit 0.
        idle_check(200);
        do_load(16'h0000, 4'b0000, 4'b0000);
        check_frame("frame_zero", 256, {4{8'h03}}, 4'b0000, 31);

`ifdef SSD_BRIGHTNESS_EN
        go_to(400);
        brightness = 4'd3;
        check_frame("frame_dim", 512, {4{8'h03}}, 4'b0000, 7);
        brightness = 4'd15;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
